// File: rtl/hud_digit_scheduler.sv
// ---------------------------------------------------------------------------
// hud_digit_scheduler
//
// Turns the binary HUD values (lives, level, score, countdown) into the seven
// BCD digits read by the number bitmap renderer, plus a visibility mask that
// blanks leading zeros of the multi-digit fields.
//
// Score and level are converted one after the other by a single sequential
// shift-add-3 (double-dabble) engine. Lives and countdown need no conversion
// once they are clamped to 9. All digits and the mask change together on the
// commit edge, so the renderer never sees a half-finished result.
//
// Ports:
//   clk          system clock
//   resetN       asynchronous active-low reset
//   update       request to sample the inputs and refresh the digits
//   lives        binary lives value      (clamped to 9)
//   level        binary level value      (clamped to 99)
//   score        binary score value      (clamped to 999)
//   countdown    binary countdown value  (clamped to 9)
//   digit        BCD digits: [0] lives, [1] level tens, [2] level units,
//                [3] score hundreds, [4] score tens, [5] score units,
//                [6] countdown
//   digitVisible 1 = digit shown (leading zeros of level/score blanked)
//   busy         conversion in progress
//   done         one-cycle pulse after new digits are committed
// ---------------------------------------------------------------------------
module hud_digit_scheduler #(
    parameter int DIGITS_NUMBER = 7,   // layout is fixed, must be 7
    parameter int CONV_BITS     = 10   // shift iterations per conversion
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          update,
    input  logic [3:0]                    lives,
    input  logic [6:0]                    level,
    input  logic [9:0]                    score,
    input  logic [3:0]                    countdown,
    output logic [DIGITS_NUMBER-1:0][3:0] digit,
    output logic [DIGITS_NUMBER-1:0]      digitVisible,
    output logic                          busy,
    output logic                          done
);

    localparam int BCD_W = 12;                   // three BCD nibbles cover 999
    localparam int SR_W  = BCD_W + CONV_BITS;
    localparam logic [3:0] LAST_ITER = 4'(CONV_BITS - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] CONV_SCORE = 2'd1;
    localparam logic [1:0] CONV_LEVEL = 2'd2;

    logic [1:0]           state;
    logic [3:0]           iter_cnt;
    logic                 pending;
    logic [SR_W-1:0]      shift_reg;
    logic [SR_W-1:0]      shift_next;
    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     score_bcd;
    logic [7:0]           level_bcd;

    // values captured when a conversion starts
    logic [3:0]           lives_cap;
    logic [3:0]           countdown_cap;
    logic [CONV_BITS-1:0] level_cap;
    logic [6:0]           vis_cap;

    // saturated inputs
    logic [3:0]           lives_sat;
    logic [3:0]           countdown_sat;
    logic [6:0]           level_sat;
    logic [9:0]           score_sat;

    logic                 last_iter;
    logic                 commit;
    logic                 start_conv;

    assign lives_sat     = (lives > 4'd9)       ? 4'd9    : lives;
    assign countdown_sat = (countdown > 4'd9)   ? 4'd9    : countdown;
    assign level_sat     = (level > 7'd99)      ? 7'd99   : level;
    assign score_sat     = (score > 10'd999)    ? 10'd999 : score;

    assign last_iter  = (iter_cnt == LAST_ITER);
    assign commit     = (state == CONV_LEVEL) && last_iter;
    // a start happens from IDLE, or back-to-back at the commit edge when a
    // request arrived during the conversion (or is present right now)
    assign start_conv = ((state == IDLE) && update) || (commit && (pending || update));

    // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    generate
        for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_nibble_adj
            logic [3:0] nib;
            assign nib = shift_reg[CONV_BITS + gi*4 +: 4];
            assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    assign shift_next = {bcd_adj[BCD_W-2:0], shift_reg[CONV_BITS-1:0], 1'b0};
    assign level_bcd  = shift_next[CONV_BITS +: 8];

    // Engine sequencing: state, iteration counter and shift register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            iter_cnt  <= 4'd0;
            shift_reg <= '0;
        end else if (start_conv) begin
            state     <= CONV_SCORE;
            iter_cnt  <= 4'd0;
            shift_reg <= {{BCD_W{1'b0}}, CONV_BITS'(score_sat)};
        end else begin
            case (state)
                CONV_SCORE: begin
                    if (last_iter) begin
                        state     <= CONV_LEVEL;
                        iter_cnt  <= 4'd0;
                        shift_reg <= {{BCD_W{1'b0}}, level_cap};
                    end else begin
                        iter_cnt  <= iter_cnt + 4'd1;
                        shift_reg <= shift_next;
                    end
                end
                CONV_LEVEL: begin
                    if (last_iter) begin
                        state    <= IDLE;
                        iter_cnt <= 4'd0;
                    end else begin
                        iter_cnt  <= iter_cnt + 4'd1;
                        shift_reg <= shift_next;
                    end
                end
                default: begin
                    state    <= IDLE;
                    iter_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Input capture; the visibility mask is decided from the clamped values
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lives_cap     <= 4'd0;
            countdown_cap <= 4'd0;
            level_cap     <= '0;
            vis_cap       <= 7'h7F;
        end else if (start_conv) begin
            lives_cap     <= lives_sat;
            countdown_cap <= countdown_sat;
            level_cap     <= CONV_BITS'(level_sat);
            vis_cap       <= {1'b1, 1'b1, (score_sat >= 10'd10), (score_sat >= 10'd100),
                              1'b1, (level_sat >= 7'd10), 1'b1};
        end
    end

    // Score result is held here while the engine works on the level
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            score_bcd <= '0;
        end else if ((state == CONV_SCORE) && last_iter) begin
            score_bcd <= shift_next[CONV_BITS +: BCD_W];
        end
    end

    // Commit: every output digit and the mask change on the same edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            digit        <= '0;
            digitVisible <= '1;
        end else if (commit) begin
            digit[0]     <= lives_cap;
            digit[1]     <= level_bcd[7:4];
            digit[2]     <= level_bcd[3:0];
            digit[3]     <= score_bcd[11:8];
            digit[4]     <= score_bcd[7:4];
            digit[5]     <= score_bcd[3:0];
            digit[6]     <= countdown_cap;
            digitVisible <= vis_cap;
        end
    end

    // Status flags; requests arriving mid-flight merge into one pending flag
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            pending <= 1'b0;
        end else begin
            done <= commit;
            if (start_conv) begin
                busy    <= 1'b1;
                pending <= 1'b0;
            end else begin
                if (commit) begin
                    busy <= 1'b0;
                end
                if ((state != IDLE) && update) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hud_digit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hud_digit_scheduler
//
// Self-checking bench for hud_digit_scheduler. Expected digits and masks come
// from a decimal-arithmetic reference model (clamp, then /10 and %10).
// ---------------------------------------------------------------------------
module tb_hud_digit_scheduler;

    logic             clk;
    logic             resetN;
    logic             update;
    logic [3:0]       lives;
    logic [6:0]       level;
    logic [9:0]       score;
    logic [3:0]       countdown;
    logic [6:0][3:0]  digit;
    logic [6:0]       digitVisible;
    logic             busy;
    logic             done;

    int checks_total;
    int checks_passed;

    logic [27:0] cur_digits;   // what the DUT should currently be showing
    logic [6:0]  cur_vis;

    hud_digit_scheduler #(
        .DIGITS_NUMBER (7),
        .CONV_BITS     (10)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .update       (update),
        .lives        (lives),
        .level        (level),
        .score        (score),
        .countdown    (countdown),
        .digit        (digit),
        .digitVisible (digitVisible),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- reference model -------------------------------------------------
    function automatic int clamp(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic logic [27:0] model_digits(input int l, input int lv, input int s, input int c);
        int ls, lvs, ss, cs;
        ls  = clamp(l, 9);
        lvs = clamp(lv, 99);
        ss  = clamp(s, 999);
        cs  = clamp(c, 9);
        // index 6 down to 0
        return {4'(cs), 4'(ss % 10), 4'((ss / 10) % 10), 4'(ss / 100),
                4'(lvs % 10), 4'(lvs / 10), 4'(ls)};
    endfunction

    function automatic logic [6:0] model_vis(input int lv, input int s);
        int lvs, ss;
        lvs = clamp(lv, 99);
        ss  = clamp(s, 999);
        return {1'b1, 1'b1, 1'(ss >= 10), 1'(ss >= 100), 1'b1, 1'(lvs >= 10), 1'b1};
    endfunction

    // ---- stimulus helpers (called 1 time unit after a rising edge) --------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input int l, input int lv, input int s, input int c);
        lives     = 4'(l);
        level     = 7'(lv);
        score     = 10'(s);
        countdown = 4'(c);
    endtask

    // One full conversion with no overlap: 20-cycle latency, single done.
    task automatic do_conv(input int l, input int lv, input int s, input int c);
        logic [27:0] exp_d;
        logic [6:0]  exp_v;
        exp_d = model_digits(l, lv, s, c);
        exp_v = model_vis(lv, s);
        set_inputs(l, lv, s, c);
        update = 1'b1;
        step();
        update = 1'b0;
        chk("busy_start", busy, 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k < 20) begin
                chk("busy_mid", busy, 1);
                chk("done_early", done, 0);
                chk("digits_stable", digit, cur_digits);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_end", busy, 0);
                chk("digits", digit, exp_d);
                chk("visible", digitVisible, exp_v);
            end
        end
        cur_digits = exp_d;
        cur_vis    = exp_v;
        step();
        chk("done_single", done, 0);
        chk("digits_hold", digit, cur_digits);
        $display("conv lives=%0d level=%0d score=%0d countdown=%0d -> digits=%h vis=%b",
                 l, lv, s, c, digit, digitVisible);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        resetN        = 1'b0;
        update        = 1'b0;
        set_inputs(0, 0, 0, 0);
        cur_digits    = '0;
        cur_vis       = 7'h7F;

        // ---- reset state ----
        step();
        step();
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("rst_digits", digit, 0);
        chk("rst_visible", digitVisible, 7'h7F);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        $display("reset idle: digits=%h vis=%b", digit, digitVisible);

        // ---- directed cases ----
        do_conv(3, 7, 245, 5);
        do_conv(15, 120, 1023, 12);   // everything saturates
        do_conv(2, 50, 1000, 1);      // 1000 clamps to 999
        do_conv(9, 99, 999, 9);
        do_conv(1, 10, 100, 0);
        do_conv(4, 9, 99, 8);

        // ---- randomized cases across full port ranges ----
        for (int i = 0; i < 16; i++) begin
            do_conv(int'($urandom_range(0, 15)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)));
        end

        // ---- two updates during a conversion: one restart, no gap ----
        begin
            logic [27:0] da, db;
            logic [6:0]  va, vb;
            int la, lva, sa, ca;
            la  = int'($urandom_range(0, 9));
            lva = int'($urandom_range(10, 99));
            sa  = int'($urandom_range(100, 999));
            ca  = int'($urandom_range(0, 9));
            da  = model_digits(la, lva, sa, ca);
            va  = model_vis(lva, sa);
            db  = model_digits(6, 10, 10, 2);
            vb  = model_vis(10, 10);
            set_inputs(la, lva, sa, ca);
            update = 1'b1;
            step();
            update = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                step();
                update = (k == 2 || k == 6);
                if (k == 2) set_inputs(6, 10, 10, 2);
                if (k < 20) begin
                    chk("pend_busy", busy, 1);
                    chk("pend_done_early", done, 0);
                    chk("pend_digits_stable", digit, cur_digits);
                end else if (k == 20) begin
                    chk("pend_done1", done, 1);
                    chk("pend_busy_restart", busy, 1);
                    chk("pend_digits1", digit, da);
                    chk("pend_vis1", digitVisible, va);
                end else if (k < 40) begin
                    chk("pend_busy2", busy, 1);
                    chk("pend_done_mid", done, 0);
                    chk("pend_digits_hold", digit, da);
                end else begin
                    chk("pend_done2", done, 1);
                    chk("pend_busy_end", busy, 0);
                    chk("pend_digits2", digit, db);
                    chk("pend_vis2", digitVisible, vb);
                end
            end
            update = 1'b0;
            cur_digits = db;
            cur_vis    = vb;
            step();
            chk("pend_no_third", busy, 0);
            $display("pending restart: first=%h second=%h vis=%b", da, digit, digitVisible);
        end

        // ---- asynchronous reset in the middle of the level conversion ----
        set_inputs(7, 42, 321, 3);
        update = 1'b1;
        step();
        update = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        resetN = 1'b0;
        #1;
        chk("arst_digits", digit, 0);
        chk("arst_visible", digitVisible, 7'h7F);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        step();
        resetN = 1'b1;
        cur_digits = '0;
        cur_vis    = 7'h7F;
        for (int k = 0; k < 25; k++) begin
            step();
            chk("arst_no_done", done, 0);
            chk("arst_idle", busy, 0);
        end
        $display("async reset mid-conversion: digits=%h vis=%b", digit, digitVisible);
        do_conv(5, 23, 678, 4);

        // ---- zero level and score: only unit digits shown ----
        do_conv(0, 0, 0, 0);
        chk("zero_vis", digitVisible, 7'b1100101);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
